seq_divider: RTL and testbench

Sequential restoring unsigned divider for the arithmetic datapath. It is the inverse counterpart of the array multiplier and reuses the same full-adder style of subtraction: each step is a trial subtract with the borrow taken from the carry chain. The block computes one quotient bit per clock over WIDTH cycles. It uses a start/busy/done handshake and holds its results until the next operation completes.

---
 rtl/seq_divider.sv | 133 +++++++++++++
 tb/tb_seq_divider.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider: one quotient bit per clock over WIDTH cycles,
// with a start/busy/done handshake and result registers that hold until the next result.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  // Handshake: start is taken only when busy==0 (IDLE or DONE); busy then stays high
  // for exactly WIDTH cycles, followed by a one-cycle done pulse with fresh results.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_sh_q, quo_sh_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_out_q, quot_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;

  // Trial subtract one bit wider than the partial remainder; the top bit is the borrow.
  always_comb begin
    r_shift = {rem_q[WIDTH-1:0], quo_sh_q[WIDTH-1]};
    diff    = {1'b0, r_shift} - {2'b00, dvs_q};
    borrow  = diff[WIDTH+1];
    r_next  = borrow ? r_shift : diff[WIDTH:0];
    q_next  = {quo_sh_q[WIDTH-2:0], ~borrow};
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quo_sh_d   = quo_sh_q;
    dvs_d      = dvs_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;
    dz_d       = dz_q;
    case (state_q)
      IDLE, DONE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d  = RUN;
          busy_d   = 1'b1;
          rem_d    = '0;
          quo_sh_d = dividend;
          dvs_d    = divisor;
          cnt_d    = CW'(WIDTH);
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        rem_d    = r_next;
        quo_sh_d = q_next;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d    = DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          quot_out_d = q_next;
          rem_out_d  = r_next[WIDTH-1:0];
          dz_d       = (dvs_q == '0);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      quo_sh_q   <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_sh_q   <= quo_sh_d;
      dvs_q      <= dvs_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
      dz_q       <= dz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_out_q;
  assign remainder   = rem_out_q;
  assign div_by_zero = dz_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at WIDTH=8: handshake timing, results, divide by zero,
// back-to-back operation, ignored mid-run start and reset abort.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  int chk_cnt = 0;
  int err_cnt = 0;

  logic [W-1:0] last_q;
  logic [W-1:0] last_r;
  logic         last_z;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Entered #1 after an edge with start already driven high; returns #1 after the done edge.
  task automatic finish_op(input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic ez, input bit inject);
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    chk("busy_at_accept", 32'(busy), 32'd1);
    chk("done_at_accept", 32'(done), 32'd0);
    for (int i = 1; i < W; i++) begin
      @(posedge clk); #1;
      start = inject && (i == 3);
      if (start) begin
        dividend = 8'd1;
        divisor  = 8'd1;
      end
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_run", 32'(done), 32'd0);
      chk("quot_hold_run", 32'(quotient), 32'(last_q));
      chk("rem_hold_run", 32'(remainder), 32'(last_r));
      chk("dz_hold_run", 32'(div_by_zero), 32'(last_z));
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("quotient", 32'(quotient), 32'(eq));
    chk("remainder", 32'(remainder), 32'(er));
    chk("div_by_zero", 32'(div_by_zero), 32'(ez));
    last_q = eq;
    last_r = er;
    last_z = ez;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic ez, input bit inject);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    finish_op(eq, er, ez, inject);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_quot_hold", 32'(quotient), 32'(last_q));
    chk("idle_rem_hold", 32'(remainder), 32'(last_r));
    chk("idle_dz_hold", 32'(div_by_zero), 32'(last_z));
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    last_q   = '0;
    last_r   = '0;
    last_z   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quot", 32'(quotient), 32'd0);
    chk("rst_rem", 32'(remainder), 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    idle_cycle();

    run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0);
    chk("state_done", 32'(dbg_state), 32'd2);
    idle_cycle();
    run_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b0);
    idle_cycle();
    run_op(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 1'b0);
    idle_cycle();
    run_op(8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 1'b0);
    idle_cycle();
    run_op(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 1'b0);
    idle_cycle();
    run_op(8'd200, 8'd0, 8'd255, 8'd200, 1'b1, 1'b0);
    idle_cycle();
    run_op(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 1'b0);
    idle_cycle();

    // Back-to-back with a stray start in the middle of the first run.
    run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b1);
    run_op(8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 1'b0);
    idle_cycle();

    // Reset in the middle of an operation.
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    last_q = '0;
    last_r = '0;
    last_z = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quot", 32'(quotient), 32'd0);
    chk("abort_rem", 32'(remainder), 32'd0);
    chk("abort_dz", 32'(div_by_zero), 32'd0);
    repeat (10) idle_cycle();
    run_op(8'd17, 8'd5, 8'd3, 8'd2, 1'b0, 1'b0);
    idle_cycle();

    for (int n = 0; n < 200; n++) begin
      a = W'($urandom_range(0, 255));
      b = ($urandom_range(0, 9) == 0) ? 8'd0 : W'($urandom_range(1, 255));
      if (b == 0) run_op(a, b, 8'd255, a, 1'b1, 1'b0);
      else        run_op(a, b, a / b, a % b, 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
